// File: rtl/clk_switch_ctrl_pkg.sv
`default_nettype none
// clk_sw_pkg: FSM encoding, select polarity and counter sizing shared by clk_switch_ctrl.
// Rev 1.0
package clk_sw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SWITCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_switch_ctrl_if.sv
`default_nettype none
// clk_switch_ctrl_if: request handshake, toggle sense inputs and switch control outputs.
// Rev 1.0
interface clk_switch_ctrl_if;

  logic req_valid;
  logic req_ready;
  logic req_sel;
  logic tgl_a;
  logic tgl_b;
  logic sel;
  logic busy;
  logic done;
  logic err;
  logic alive_a;
  logic alive_b;
  logic failover;

  modport master (
    output req_valid, req_sel, tgl_a, tgl_b,
    input  req_ready, sel, busy, done, err, alive_a, alive_b, failover
  );

  modport slave (
    input  req_valid, req_sel, tgl_a, tgl_b,
    output req_ready, sel, busy, done, err, alive_a, alive_b, failover
  );

endinterface
`default_nettype wire

// File: rtl/clk_switch_ctrl_alive_mon.sv
`default_nettype none
// clk_alive_mon: synchronises a source-domain toggle and flags the source dead after ALIVE_WIN quiet cycles.
// Rev 1.0
module clk_alive_mon
  import clk_sw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ALIVE_WIN   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl,
  output logic alive
);

  localparam int CW = cnt_width(ALIVE_WIN, 0);
  localparam logic [CW-1:0] c_win = CW'(ALIVE_WIN);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic                   r_seen;
  logic [CW-1:0]          r_wd;
  logic                   w_edge;

  assign w_edge = r_sync[SYNC_STAGES-1] ^ r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_last <= 1'b0;
      r_seen <= 1'b0;
      r_wd   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tgl};
      r_last <= r_sync[SYNC_STAGES-1];
      if (w_edge) begin
        r_wd   <= '0;
        r_seen <= 1'b1;
      end else if (r_wd < c_win) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  // Watchdog saturates at the window, so alive stays low until the next edge.
  assign alive = r_seen && (r_wd < c_win);

endmodule
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// clk_switch_ctrl: checks target liveness, drives the glitch-free switch select, reports done/err.
// Rev 1.0 -- define CLK_SW_FAILOVER_EN for automatic failover when the selected source dies.
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ALIVE_WIN   = 16,
  parameter int SETTLE_CYC  = 8,
  parameter bit RESET_SEL   = SEL_A
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_switch_ctrl_if.slave bus
);

  localparam int CW = cnt_width(ALIVE_WIN, SETTLE_CYC);
  localparam logic [CW-1:0] c_check_last  = CW'(ALIVE_WIN - 1);
  localparam logic [CW-1:0] c_settle_last = CW'(SETTLE_CYC - 1);

  state_t        r_state, w_next;
  logic          r_sel, r_tgt, r_rdy_en;
  logic [CW-1:0] r_cnt;
  logic          w_alive_a, w_alive_b, w_alive_tgt;
  logic          w_trig, w_fo_pend, w_accept;
  logic          w_ready, w_busy, w_done, w_err, w_failover;

  clk_alive_mon #(.SYNC_STAGES(SYNC_STAGES), .ALIVE_WIN(ALIVE_WIN)) u_mon_a (
    .clk(clk), .rst_n(rst_n), .tgl(bus.tgl_a), .alive(w_alive_a)
  );

  clk_alive_mon #(.SYNC_STAGES(SYNC_STAGES), .ALIVE_WIN(ALIVE_WIN)) u_mon_b (
    .clk(clk), .rst_n(rst_n), .tgl(bus.tgl_b), .alive(w_alive_b)
  );

  assign w_alive_tgt = (r_tgt == SEL_A) ? w_alive_a : w_alive_b;
  assign w_accept    = bus.req_valid && w_ready;

`ifdef CLK_SW_FAILOVER_EN
  logic r_alive_a_d, r_alive_b_d, r_fo;

  // Trigger only on the falling edge of the selected source's alive, with the other one usable.
  assign w_trig = r_rdy_en && (r_state == ST_IDLE) &&
                  ((r_sel == SEL_A) ? (r_alive_a_d && !w_alive_a && w_alive_b)
                                    : (r_alive_b_d && !w_alive_b && w_alive_a));
  assign w_fo_pend = r_fo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive_a_d <= 1'b0;
      r_alive_b_d <= 1'b0;
      r_fo        <= 1'b0;
    end else begin
      r_alive_a_d <= w_alive_a;
      r_alive_b_d <= w_alive_b;
      if (r_state == ST_IDLE) r_fo <= w_trig;
    end
  end
`else
  assign w_trig    = 1'b0;
  assign w_fo_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_trig)        w_next = ST_SWITCH;
        else if (w_accept) w_next = (bus.req_sel == r_sel) ? ST_DONE : ST_CHECK;
      end
      ST_CHECK: begin
        if (w_alive_tgt)                 w_next = ST_SWITCH;
        else if (r_cnt == c_check_last)  w_next = ST_ERR;
      end
      ST_SWITCH: w_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == c_settle_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      ST_ERR:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_sel    <= RESET_SEL;
      r_tgt    <= RESET_SEL;
      r_cnt    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (r_state == ST_IDLE) begin
        if (w_trig)        r_tgt <= ~r_sel;
        else if (w_accept) r_tgt <= bus.req_sel;
      end
      if (r_state == ST_SWITCH) r_sel <= r_tgt;
      // One counter serves both CHECK timeout and SETTLE; it restarts on every state change.
      if (((r_state == ST_CHECK) || (r_state == ST_SETTLE)) && (w_next == r_state))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    w_ready    = r_rdy_en && (r_state == ST_IDLE) && !w_trig;
    w_busy     = (r_state != ST_IDLE);
    w_done     = (r_state == ST_DONE) && !w_fo_pend;
    w_failover = (r_state == ST_DONE) && w_fo_pend;
    w_err      = (r_state == ST_ERR);
  end

  assign bus.req_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = w_err;
  assign bus.failover  = w_failover;
  assign bus.sel       = r_sel;
  assign bus.alive_a   = w_alive_a;
  assign bus.alive_b   = w_alive_b;

endmodule
`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
`default_nettype none
// tb_clk_switch_ctrl: directed scenarios plus randomized toggles/requests against a timestamp-based model.
// Rev 1.0
module tb_clk_switch_ctrl;

  localparam int SYNC = 2;
  localparam int AW   = 16;
  localparam int SC   = 8;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_switch_ctrl_if bus();

  clk_switch_ctrl #(
    .SYNC_STAGES(SYNC), .ALIVE_WIN(AW), .SETTLE_CYC(SC), .RESET_SEL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc;
  bit tga [0:MAXC];
  bit tgb [0:MAXC];

  // Model: tga/tgb[k] is the toggle level sampled at reference edge k (index 0 = reset value).
  bit m_sel, m_new_sel;
  int m_idle_at, m_done_at, m_err_at, m_fo_at, m_chg_at;

  function automatic bit tg(bit src, int k);
    return src ? tga[k] : tgb[k];
  endfunction

  // Alive after edge n: a transition sampled at edge k is seen at edge k+SYNC; dead AW cycles later.
  function automatic bit alive_exp(bit src, int n);
    for (int k = n - SYNC; k >= 1; k--) begin
      if (n - k - SYNC >= AW) return 1'b0;
      if (tg(src, k) != tg(src, k - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit trig_exp(int n);
`ifdef CLK_SW_FAILOVER_EN
    return (n >= 1) && (n >= m_idle_at) && alive_exp(m_sel, n - 1) &&
           !alive_exp(m_sel, n) && alive_exp(!m_sel, n);
`else
    return (n < 0);
`endif
  endfunction

  function automatic bit ready_exp(int n);
    return (n >= 1) && (n >= m_idle_at) && !trig_exp(n);
  endfunction

  task automatic model_edge(int n, bit valid, bit rsel);
    int found;
    if (n - 1 >= m_idle_at) begin
      if (trig_exp(n - 1)) begin
        m_new_sel = !m_sel;
        m_chg_at  = n + 1;
        m_fo_at   = n + SC + 1;
        m_idle_at = n + SC + 2;
      end else if (valid && ready_exp(n - 1)) begin
        if (rsel == m_sel) begin
          m_done_at = n;
          m_idle_at = n + 1;
        end else begin
          found = -1;
          for (int j = 0; j < AW; j++)
            if (found < 0 && alive_exp(rsel, n + j)) found = j;
          if (found >= 0) begin
            m_new_sel = rsel;
            m_chg_at  = n + 2 + found;
            m_done_at = n + SC + 2 + found;
            m_idle_at = n + SC + 3 + found;
          end else begin
            m_err_at  = n + AW;
            m_idle_at = n + AW + 1;
          end
        end
      end
    end
    if (n == m_chg_at) m_sel = m_new_sel;
  endtask

  task automatic set_wave(bit src, int from, int to, int per);
    bit v = 1'b0;
    for (int k = 0; k <= MAXC; k++) begin
      if (k > 0 && k >= from && k <= to && ((k - from) % per) == 0) v = ~v;
      if (src) tga[k] = v; else tgb[k] = v;
    end
  endtask

  task automatic gen_wave(bit src);
    bit v = 1'b0;
    int k = 1;
    int seg, per;
    bit tog;
    if (src) tga[0] = 1'b0; else tgb[0] = 1'b0;
    while (k <= MAXC) begin
      seg = $urandom_range(5, 60);
      tog = ($urandom_range(0, 2) != 0);
      per = $urandom_range(1, 4);
      for (int i = 0; i < seg && k <= MAXC; i++) begin
        if (tog && (i % per) == 0) v = ~v;
        if (src) tga[k] = v; else tgb[k] = v;
        k++;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sel   = 1'b0;
    bus.tgl_a     = 1'b0;
    bus.tgl_b     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    rst_n     = 1'b1;
    cyc       = 0;
    m_sel     = 1'b1;
    m_new_sel = 1'b1;
    m_idle_at = 0;
    m_done_at = -1;
    m_err_at  = -1;
    m_fo_at   = -1;
    m_chg_at  = -1;
    bus.req_valid = 1'b0;
    bus.tgl_a = tga[1];
    bus.tgl_b = tgb[1];
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(cyc, bus.req_valid, bus.req_sel);
    @(negedge clk);
    bus.tgl_a     = tga[cyc + 1];
    bus.tgl_b     = tgb[cyc + 1];
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    set_wave(1'b1, 0, -1, 1);
    set_wave(1'b0, 0, -1, 1);
    apply_reset();
    got = {bus.req_ready, bus.busy, bus.sel, bus.done, bus.err, bus.alive_a, bus.alive_b, bus.failover};
    n_checks++;
    if (got !== 8'b0010_0000) begin
      n_err++;
      $display("FAIL reset_values got=%b exp=%b", got, 8'b0010_0000);
    end
    release_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      got = {bus.req_ready, bus.busy, bus.sel, bus.done, bus.err, bus.alive_a, bus.alive_b, bus.failover};
      n_checks++;
      if (got !== 8'b1010_0000) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, got, 8'b1010_0000);
      end
    end
  endtask

  task automatic test_switch();
    int t;
    logic [5:0] got, exp;
    set_wave(1'b1, 1, MAXC, 3);
    set_wave(1'b0, 1, MAXC, 3);
    apply_reset();
    release_reset();
    repeat (10) step();
    bus.req_valid = 1'b1;
    bus.req_sel   = 1'b0;
    t = cyc + 1;
    for (int i = 0; i < SC + 6; i++) begin
      step();
      got = {bus.req_ready, bus.busy, bus.sel, bus.done, bus.err, bus.alive_b};
      exp = {!(cyc <= t + SC + 2), (cyc <= t + SC + 2), !(cyc >= t + 2),
             (cyc == t + SC + 2), 1'b0, 1'b1};
      n_checks++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL switch_to_b cyc=%0d t=%0d got=%b exp=%b", cyc, t, got, exp);
      end
    end
  endtask

  task automatic test_same_sel();
    int t;
    logic [4:0] got, exp;
    set_wave(1'b1, 1, MAXC, 3);
    set_wave(1'b0, 1, MAXC, 3);
    apply_reset();
    release_reset();
    repeat (10) step();
    bus.req_valid = 1'b1;
    bus.req_sel   = 1'b1;
    t = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      step();
      got = {bus.req_ready, bus.busy, bus.sel, bus.done, bus.err};
      exp = {(cyc != t), (cyc == t), 1'b1, (cyc == t), 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL same_sel cyc=%0d t=%0d got=%b exp=%b", cyc, t, got, exp);
      end
    end
  endtask

  task automatic test_dead_target();
    int t;
    logic [4:0] got, exp;
    set_wave(1'b1, 1, MAXC, 2);
    set_wave(1'b0, 0, -1, 1);
    apply_reset();
    release_reset();
    repeat (10) step();
    bus.req_valid = 1'b1;
    bus.req_sel   = 1'b0;
    t = cyc + 1;
    for (int i = 0; i < AW + 4; i++) begin
      step();
      got = {bus.req_ready, bus.busy, bus.sel, bus.done, bus.err};
      exp = {(cyc > t + AW), (cyc <= t + AW), 1'b1, 1'b0, (cyc == t + AW)};
      n_checks++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL dead_target cyc=%0d t=%0d got=%b exp=%b", cyc, t, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [4:0] got;
    set_wave(1'b1, 1, MAXC, 3);
    set_wave(1'b0, 1, MAXC, 3);
    apply_reset();
    release_reset();
    repeat (10) step();
    bus.req_valid = 1'b1;
    bus.req_sel   = 1'b0;
    t = cyc + 1;
    while (cyc < t + 5) step();
    n_checks++;
    if ({bus.sel, bus.busy} !== 2'b01) begin
      n_err++;
      $display("FAIL settle_before_reset got sel/busy=%b exp=01", {bus.sel, bus.busy});
    end
    #2 rst_n = 1'b0;
    #1;
    got = {bus.req_ready, bus.busy, bus.sel, bus.done, bus.err};
    n_checks++;
    if (got !== 5'b00100) begin
      n_err++;
      $display("FAIL async_reset got=%b exp=%b", got, 5'b00100);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({bus.done, bus.err, bus.sel} !== 3'b001) begin
        n_err++;
        $display("FAIL in_reset got done/err/sel=%b exp=001", {bus.done, bus.err, bus.sel});
      end
    end
    release_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      got = {bus.req_ready, bus.busy, bus.sel, bus.done, bus.err};
      n_checks++;
      if (got !== 5'b10100) begin
        n_err++;
        $display("FAIL after_reset cyc=%0d got=%b exp=%b", cyc, got, 5'b10100);
      end
    end
  endtask

  // Source a stops after its transition at edge 40, so alive_a falls after edge 40+SYNC+AW.
  task automatic test_failover();
    int f;
    logic [4:0] got, exp;
    set_wave(1'b1, 1, 40, 3);
    set_wave(1'b0, 1, MAXC, 3);
    apply_reset();
    release_reset();
    f = 40 + SYNC + AW;
    while (cyc < f + SC + 5) begin
      step();
      got = {bus.alive_a, bus.sel, bus.busy, bus.done, bus.failover};
`ifdef CLK_SW_FAILOVER_EN
      exp = {(cyc >= 3 && cyc < f), !(cyc >= f + 2), (cyc >= f + 1 && cyc <= f + 2 + SC),
             1'b0, (cyc == f + 2 + SC)};
`else
      exp = {(cyc >= 3 && cyc < f), 1'b1, 1'b0, 1'b0, 1'b0};
`endif
      n_checks++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL failover cyc=%0d f=%0d got=%b exp=%b", cyc, f, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    for (int r = 0; r < 3; r++) begin
      gen_wave(1'b1);
      gen_wave(1'b0);
      apply_reset();
      release_reset();
      for (int i = 0; i < 1200; i++) begin
        bus.req_valid = ($urandom_range(0, 99) < 30);
        bus.req_sel   = $urandom_range(0, 1);
        step();
        got = {bus.req_ready, bus.busy, bus.sel, bus.done, bus.err, bus.alive_a, bus.alive_b, bus.failover};
        exp = {ready_exp(cyc), (cyc < m_idle_at), m_sel, (cyc == m_done_at), (cyc == m_err_at),
               alive_exp(1'b1, cyc), alive_exp(1'b0, cyc), (cyc == m_fo_at)};
        n_checks++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL random r=%0d cyc=%0d got=%b exp=%b", r, cyc, got, exp);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_switch();
    test_same_sel();
    test_dead_target();
    test_reset_mid();
    test_failover();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
